// File: rtl/rps_score_keeper.sv
// Rock-paper-scissors score keeper: tallies judged rounds, holds each
// result for a display window and declares the match winner.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   round_valid    result carries a judged round this cycle
//   result         000 P1, 001 P2, 010 tie, others invalid
//   new_match      clear scores and start a new match
//   ready          round accepted this cycle if round_valid (state PLAY)
//   p1_score       P1 points
//   p2_score       P2 points
//   tie_count      tied rounds (saturating)
//   invalid_count  invalid rounds (saturating)
//   last_result    raw code of last accepted round, 100 when none
//   match_over     winner declared
//   winner         00 none, 01 P1, 10 P2
module rps_score_keeper #(
    parameter int WIN_TARGET  = 3,
    parameter int SCORE_W     = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               round_valid,
    input  logic [2:0]         result,
    input  logic               new_match,
    output logic               ready,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [SCORE_W-1:0] tie_count,
    output logic [SCORE_W-1:0] invalid_count,
    output logic [2:0]         last_result,
    output logic               match_over,
    output logic [1:0]         winner
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WT        = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] ONE       = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SAT       = '1;
    localparam logic [2:0]         NO_RES    = 3'b100;

    typedef enum logic [1:0] {
        S_PLAY,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [HW-1:0]      r_hold_cnt;
    logic [SCORE_W-1:0] r_p1;
    logic [SCORE_W-1:0] r_p2;
    logic [SCORE_W-1:0] r_tie;
    logic [SCORE_W-1:0] r_inv;
    logic [2:0]         r_last;
    logic               r_over;
    logic [1:0]         r_winner;

    logic [SCORE_W-1:0] w_p1_inc;
    logic [SCORE_W-1:0] w_p2_inc;

    always_comb begin
        w_p1_inc = r_p1 + ONE;
        w_p2_inc = r_p2 + ONE;
    end

    always_ff @(posedge clk) begin
        if (reset || new_match) begin
            // new_match clears to exactly the power-on state
            r_state    <= S_PLAY;
            r_hold_cnt <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_tie      <= '0;
            r_inv      <= '0;
            r_last     <= NO_RES;
            r_over     <= 1'b0;
            r_winner   <= 2'b00;
        end else begin
            unique case (r_state)
                S_PLAY: begin
                    if (round_valid) begin
                        r_last     <= result;
                        r_hold_cnt <= '0;
                        r_state    <= S_HOLD;
                        case (result)
                            3'b000: begin
                                r_p1 <= w_p1_inc;
                                if (w_p1_inc == WT) begin
                                    r_state  <= S_DONE;
                                    r_over   <= 1'b1;
                                    r_winner <= 2'b01;
                                end
                            end
                            3'b001: begin
                                r_p2 <= w_p2_inc;
                                if (w_p2_inc == WT) begin
                                    r_state  <= S_DONE;
                                    r_over   <= 1'b1;
                                    r_winner <= 2'b10;
                                end
                            end
                            3'b010: begin
                                if (r_tie != SAT) r_tie <= r_tie + ONE;
                            end
                            default: begin
                                if (r_inv != SAT) r_inv <= r_inv + ONE;
                            end
                        endcase
                    end
                end
                S_HOLD: begin
                    // incoming rounds are dropped while the result is shown
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt <= '0;
                        r_state    <= S_PLAY;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_PLAY;
                end
            endcase
        end
    end

    assign ready         = (r_state == S_PLAY);
    assign p1_score      = r_p1;
    assign p2_score      = r_p2;
    assign tie_count     = r_tie;
    assign invalid_count = r_inv;
    assign last_result   = r_last;
    assign match_over    = r_over;
    assign winner        = r_winner;

endmodule

// File: tb/tb_rps_score_keeper.sv
// Directed bench for rps_score_keeper (WIN_TARGET=3, SCORE_W=4,
// HOLD_CYCLES=8): scoring, hold window, match end, clear, reset, saturation.
module tb_rps_score_keeper;

    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       round_valid;
    logic [2:0] result;
    logic       new_match;
    logic       ready;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] tie_count;
    logic [3:0] invalid_count;
    logic [2:0] last_result;
    logic       match_over;
    logic [1:0] winner;

    int tests = 0;
    int fails = 0;

    rps_score_keeper #(
        .WIN_TARGET (3),
        .SCORE_W    (4),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .round_valid  (round_valid),
        .result       (result),
        .new_match    (new_match),
        .ready        (ready),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .tie_count    (tie_count),
        .invalid_count(invalid_count),
        .last_result  (last_result),
        .match_over   (match_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // present one round for a single edge, then wait out the hold window
    task automatic accept(input logic [2:0] code);
        round_valid = 1'b1;
        result      = code;
        step();
        round_valid = 1'b0;
        repeat (HOLD) step();
    endtask

    task automatic pulse_new_match();
        new_match = 1'b1;
        step();
        new_match = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 8'(ready), 8'd1);
        chk({tag, "_p1"}, 8'(p1_score), 8'd0);
        chk({tag, "_p2"}, 8'(p2_score), 8'd0);
        chk({tag, "_tie"}, 8'(tie_count), 8'd0);
        chk({tag, "_inv"}, 8'(invalid_count), 8'd0);
        chk({tag, "_last"}, 8'(last_result), 8'h4);
        chk({tag, "_over"}, 8'(match_over), 8'd0);
        chk({tag, "_win"}, 8'(winner), 8'd0);
    endtask

    initial begin
        reset       = 1'b1;
        round_valid = 1'b0;
        result      = 3'b000;
        new_match   = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_idle("rst");

        // T1: P1 wins three rounds
        round_valid = 1'b1;
        result      = 3'b000;
        step();
        round_valid = 1'b0;
        chk("t1_p1_a", 8'(p1_score), 8'd1);
        chk("t1_rdy_a", 8'(ready), 8'd0);
        repeat (HOLD) step();
        accept(3'b000);
        chk("t1_p1_b", 8'(p1_score), 8'd2);
        accept(3'b000);
        chk("t1_p1_c", 8'(p1_score), 8'd3);
        chk("t1_over", 8'(match_over), 8'd1);
        chk("t1_win", 8'(winner), 8'd1);
        chk("t1_rdy", 8'(ready), 8'd0);

        // T4: rounds ignored in DONE, then new match
        round_valid = 1'b1;
        result      = 3'b001;
        repeat (3) step();
        round_valid = 1'b0;
        chk("t4_p2", 8'(p2_score), 8'd0);
        chk("t4_p1", 8'(p1_score), 8'd3);
        chk("t4_last", 8'(last_result), 8'd0);
        chk("t4_over", 8'(match_over), 8'd1);
        pulse_new_match();
        chk_idle("t4_nm");

        // T2: second pulse inside HOLD is dropped; ready back after 8
        round_valid = 1'b1;
        result      = 3'b001;
        step();
        round_valid = 1'b0;
        chk("t2_rdy0", 8'(ready), 8'd0);
        for (int i = 1; i <= HOLD; i++) begin
            round_valid = (i == 2);
            step();
            chk($sformatf("t2_rdy%0d", i), 8'(ready), 8'(i == HOLD));
        end
        round_valid = 1'b0;
        chk("t2_p2", 8'(p2_score), 8'd1);
        chk("t2_last", 8'(last_result), 8'd1);

        // T3: tie, invalid, other invalid code
        pulse_new_match();
        accept(3'b010);
        accept(3'b100);
        accept(3'b111);
        chk("t3_tie", 8'(tie_count), 8'd1);
        chk("t3_inv", 8'(invalid_count), 8'd2);
        chk("t3_p1", 8'(p1_score), 8'd0);
        chk("t3_p2", 8'(p2_score), 8'd0);
        chk("t3_last", 8'(last_result), 8'h7);

        // T5: reset during HOLD
        pulse_new_match();
        accept(3'b000);
        round_valid = 1'b1;
        result      = 3'b000;
        step();
        round_valid = 1'b0;
        step();
        chk("t5_p1", 8'(p1_score), 8'd2);
        chk("t5_rdy", 8'(ready), 8'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("t5_rst");

        // T6: new_match beats round_valid
        new_match   = 1'b1;
        round_valid = 1'b1;
        result      = 3'b000;
        step();
        new_match   = 1'b0;
        round_valid = 1'b0;
        chk("t6_p1", 8'(p1_score), 8'd0);
        chk("t6_rdy", 8'(ready), 8'd1);
        chk("t6_last", 8'(last_result), 8'h4);

        // tie counter saturation
        for (int i = 0; i < 15; i++) accept(3'b010);
        chk("sat_15", 8'(tie_count), 8'd15);
        accept(3'b010);
        chk("sat_16", 8'(tie_count), 8'd15);
        chk("sat_last", 8'(last_result), 8'h2);
        chk("sat_rdy", 8'(ready), 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
